vga_scanner: RTL and testbench
==============================

VGA_SCANNER -- requirements
Module: vga_scanner

Interface
REQ-001 The block SHALL have parameter IMG_W, default 480: image width in pixels; IMG_W*IMG_H SHALL NOT exceed 262144.
REQ-002 The block SHALL have parameter IMG_H, default 480: image height in lines; IMG_H SHALL NOT exceed 480.
REQ-003 The block SHALL have parameter X0, default 80: first visible column of the image window; X0+IMG_W SHALL NOT exceed 640.
REQ-004 Port rdClk  in  1: 25 MHz pixel clock; all logic SHALL be on its rising edge.
REQ-005 Port reset  in  1: synchronous, active-low reset.
REQ-006 Port en  in  1: scan enable.
REQ-007 Ports R, G, B  in  8 each: pixel colour from video memory, registered there one rdClk after re/pxlAddr.
REQ-008 Port re  out  1: video memory read enable.
REQ-009 Port pxlAddr  out  18: video memory word address.
REQ-010 Ports vgaR, vgaG, vgaB  out  8 each: DAC colour.
REQ-011 Ports hsync, vsync  out  1 each: active-low sync pulses.
REQ-012 Port blank_n  out  1: high during the visible 640x480 area.
REQ-013 Port frameStart  out  1: one-cycle pulse aligned with the first visible pixel of each frame.

Function
REQ-014 hcnt SHALL count 0..799 and wrap to 0; vcnt SHALL advance by 1 when hcnt wraps, counting 0..524 and wrapping to 0.
REQ-015 Visible area SHALL be hcnt<640 and vcnt<480.
REQ-016 Sync SHALL be raw hsync low for 656<=hcnt<752 and raw vsync low for 490<=vcnt<492.
REQ-017 Window SHALL be X0<=hcnt<X0+IMG_W and vcnt<IMG_H.
REQ-018 The address counter SHALL clear to 0 when hcnt=0 and vcnt=0, and increment by 1 after each window pixel; no multiplier SHALL be used.
REQ-019 Stage 1 SHALL register re=window and pxlAddr=address counter; pxlAddr SHALL hold its last value while re=0.
REQ-020 Stage 2 is the video memory pixel register, which is external to this block.
REQ-021 Stage 3 SHALL register vgaR/G/B = R/G/B when the stage-2-delayed window flag is 1, otherwise 0.
REQ-022 hsync, vsync, blank_n and frameStart SHALL be delayed by PIPE=3 registers so they align with vgaR/G/B.
REQ-023 Counter-to-output latency SHALL be exactly 3 cycles.
REQ-024 frameStart SHALL be the raw condition hcnt=0 and vcnt=0, delayed by 3 cycles.
REQ-025 When en=0, counters SHALL be held at 0, re SHALL be 0, and the raw window, blank_n and frameStart conditions SHALL be forced inactive with raw syncs high; the delay pipeline SHALL keep shifting.
REQ-026 When en rises, scanning SHALL start at hcnt=0, vcnt=0 on the next cycle.
REQ-027 If en falls mid-frame, the scan SHALL abort immediately; the frame SHALL NOT complete.
REQ-028 On window-edge columns, re SHALL deassert in the same stage-1 cycle in which hcnt reaches X0+IMG_W; no address SHALL be skipped or repeated across lines.
REQ-029 After the last window pixel, the address SHALL hold until the frame-start clear; it SHALL NOT wrap within a frame.

Reset
REQ-030 With reset=0 at a rising edge, the block SHALL set hcnt, vcnt, the address counter and pxlAddr to 0.
REQ-031 With reset=0 at a rising edge, the block SHALL set re, vgaR/G/B, blank_n and frameStart to 0, and hsync and vsync to 1.
REQ-032 Reset SHALL clear every delay-pipeline stage to its idle value.
REQ-033 Reset SHALL override en.
REQ-034 Reset asserted mid-frame SHALL restart the scan at hcnt=0, vcnt=0 after release, with the first visible outputs 3 cycles later.

Structure
REQ-035 Package vga_pkg SHALL hold H_VIS=640, H_FP_END=656, H_SYNC_END=752, H_TOT=800, V_VIS=480, V_SYNC_START=490, V_SYNC_END=492, V_TOT=525, PIPE=3, ADDR_W=18 and a vga_sync_t struct {hs, vs, blank_n, win, fs}.
REQ-036 Sub-module vga_timing SHALL own hcnt/vcnt and raw vga_sync_t generation.
REQ-037 vga_scanner SHALL own the address counter, stages 1 and 3, and the delay pipeline.

Verification
REQ-038 Bench: reset then en=1 -> at counter (h=80, v=0), pxlAddr=0 and re=1; at (559, 0) pxlAddr=479; at (80, 1) pxlAddr=480; at (559, 479) pxlAddr=230399; next frame's first window pixel pxlAddr=0.
REQ-039 Bench: behavioural 1-cycle memory returning R=addr[7:0] -> vgaR equals (pxlAddr sample)[7:0] exactly 2 cycles after that pxlAddr; vgaR=0 for columns 0..79 and 560..639.
REQ-040 Bench: count cycles over one full frame -> 800 cycles per line; hsync low for exactly 96 cycles per line; vsync low for exactly 2 lines (1600 cycles); 420000 cycles per frame.
REQ-041 Bench: en=0 at (h=300, v=200) for 10 cycles then en=1 -> re=0 and syncs high within 3 cycles; scan restarts at (0, 0); frameStart pulses 3 cycles after restart.
REQ-042 Bench: reset=0 for 1 cycle at (h=700, v=491) -> all outputs at reset values next cycle; hsync/vsync high; normal timing resumes from (0, 0).
REQ-043 Bench: IMG_W=256, IMG_H=256, X0=192 -> re high for columns 192..447 on lines 0..255 only; last address 65535.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, raw sync bundle and small helpers.
package vga_pkg;

  // Raster counter width (covers 0..799 and 0..524).
  localparam int unsigned CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  // Horizontal timing, in pixel clocks.
  localparam cnt_t H_VIS      = 10'd640;
  localparam cnt_t H_FP_END   = 10'd656;
  localparam cnt_t H_SYNC_END = 10'd752;
  localparam cnt_t H_TOT      = 10'd800;
  localparam cnt_t H_MAX      = H_TOT - 10'd1;

  // Vertical timing, in lines.
  localparam cnt_t V_VIS        = 10'd480;
  localparam cnt_t V_SYNC_START = 10'd490;
  localparam cnt_t V_SYNC_END   = 10'd492;
  localparam cnt_t V_TOT        = 10'd525;
  localparam cnt_t V_MAX        = V_TOT - 10'd1;

  // Registers between the raster counters and the DAC outputs.
  localparam int unsigned PIPE = 3;

  // Video memory word address width.
  localparam int unsigned ADDR_W = 18;
  typedef logic [ADDR_W-1:0] addr_t;

  // Per-pixel raw flags produced from the counters; syncs are active-low.
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
    logic win;
    logic fs;
  } vga_sync_t;

  // Value of every delay stage while idle or in reset.
  localparam vga_sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0, win: 1'b0, fs: 1'b0};

  // Half-open interval test lo <= v < hi.
  function automatic logic in_range(input cnt_t v, input cnt_t lo, input cnt_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters and raw (undelayed) sync/window/frame-start generation.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned IMG_W = 480,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned X0    = 80
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [CNT_W-1:0] hcnt_o,
  output logic [CNT_W-1:0] vcnt_o,
  output vga_sync_t        sync_o
);

  localparam cnt_t WinXStart = cnt_t'(X0);
  localparam cnt_t WinXEnd   = cnt_t'(X0 + IMG_W);
  localparam cnt_t WinYEnd   = cnt_t'(IMG_H);

  cnt_t      hcnt_q, hcnt_d;
  cnt_t      vcnt_q, vcnt_d;
  logic      h_wrap;
  vga_sync_t sync_raw;

  // Next raster position: free-running while enabled, parked at the origin otherwise.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    h_wrap = (hcnt_q == H_MAX);
    if (!en_i) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else begin
      hcnt_d = h_wrap ? '0 : hcnt_q + 10'd1;
      if (h_wrap) begin
        vcnt_d = (vcnt_q == V_MAX) ? '0 : vcnt_q + 10'd1;
      end
    end
  end

  // Counter registers; reset wins over enable.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Raw flags for the current position; a disabled scan looks exactly like idle.
  always_comb begin
    sync_raw = SYNC_IDLE;
    if (en_i) begin
      sync_raw.hs      = !in_range(hcnt_q, H_FP_END, H_SYNC_END);
      sync_raw.vs      = !in_range(vcnt_q, V_SYNC_START, V_SYNC_END);
      sync_raw.blank_n = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
      sync_raw.win     = in_range(hcnt_q, WinXStart, WinXEnd) && (vcnt_q < WinYEnd);
      sync_raw.fs      = (hcnt_q == '0) && (vcnt_q == '0);
    end
  end

  assign hcnt_o = hcnt_q;
  assign vcnt_o = vcnt_q;
  assign sync_o = sync_raw;

endmodule

// File: rtl/vga_scanner.sv
// VGA scanner: walks the image window in raster order, issues video memory reads
// and aligns returned pixels with delayed sync/blank/frame-start to the DAC.
module vga_scanner
  import vga_pkg::*;
#(
  parameter int unsigned IMG_W = 480,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned X0    = 80
) (
  input  logic              rdClk,
  input  logic              reset,
  input  logic              en,
  input  logic [7:0]        R,
  input  logic [7:0]        G,
  input  logic [7:0]        B,
  output logic              re,
  output logic [ADDR_W-1:0] pxlAddr,
  output logic [7:0]        vgaR,
  output logic [7:0]        vgaG,
  output logic [7:0]        vgaB,
  output logic              hsync,
  output logic              vsync,
  output logic              blank_n,
  output logic              frameStart
);

  // Address of the final window pixel; the counter saturates here so it never wraps.
  localparam addr_t LastAddr = addr_t'(IMG_W * IMG_H - 1);
  // Stage index whose window flag lines up with the memory's registered pixel.
  localparam int unsigned ColStage = PIPE - 2;

  logic [CNT_W-1:0] hcnt, vcnt;
  vga_sync_t        sync_raw;

  vga_timing #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .X0    (X0)
  ) u_timing (
    .clk_i  (rdClk),
    .rst_ni (reset),
    .en_i   (en),
    .hcnt_o (hcnt),
    .vcnt_o (vcnt),
    .sync_o (sync_raw)
  );

  addr_t     addr_q, addr_d;
  addr_t     cur_addr;
  addr_t     pxl_addr_q, pxl_addr_d;
  logic      frame_origin;
  vga_sync_t sync_q [PIPE-1];
  logic      hsync_q, vsync_q, blank_n_q, frame_start_q;
  logic [7:0] vga_r_q, vga_g_q, vga_b_q;

  // Address for the current window pixel and the next one; the origin restarts at 0
  // so the first window pixel of every frame reads address 0 even when X0 is 0.
  always_comb begin
    frame_origin = (hcnt == '0) && (vcnt == '0);
    cur_addr     = frame_origin ? '0 : addr_q;
    addr_d       = cur_addr;
    if (sync_raw.win && (cur_addr != LastAddr)) begin
      addr_d = cur_addr + addr_t'(1);
    end
    pxl_addr_d = sync_raw.win ? cur_addr : pxl_addr_q;
  end

  // Address counter and stage-1 memory address register.
  always_ff @(posedge rdClk) begin
    if (!reset) begin
      addr_q     <= '0;
      pxl_addr_q <= '0;
    end else begin
      addr_q     <= addr_d;
      pxl_addr_q <= pxl_addr_d;
    end
  end

  // Delay line for the raw flags; stage 0 doubles as the stage-1 read enable.
  always_ff @(posedge rdClk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < PIPE - 1; i++) begin
        sync_q[i] <= SYNC_IDLE;
      end
    end else begin
      sync_q[0] <= sync_raw;
      for (int unsigned i = 1; i < PIPE - 1; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Stage 3: final sync/blank/frame-start registers.
  always_ff @(posedge rdClk) begin
    if (!reset) begin
      hsync_q       <= SYNC_IDLE.hs;
      vsync_q       <= SYNC_IDLE.vs;
      blank_n_q     <= SYNC_IDLE.blank_n;
      frame_start_q <= SYNC_IDLE.fs;
    end else begin
      hsync_q       <= sync_q[PIPE-2].hs;
      vsync_q       <= sync_q[PIPE-2].vs;
      blank_n_q     <= sync_q[PIPE-2].blank_n;
      frame_start_q <= sync_q[PIPE-2].fs;
    end
  end

  // Stage 3: capture memory pixel inside the window, black everywhere else.
  always_ff @(posedge rdClk) begin
    if (!reset) begin
      vga_r_q <= '0;
      vga_g_q <= '0;
      vga_b_q <= '0;
    end else if (sync_q[ColStage].win) begin
      vga_r_q <= R;
      vga_g_q <= G;
      vga_b_q <= B;
    end else begin
      vga_r_q <= '0;
      vga_g_q <= '0;
      vga_b_q <= '0;
    end
  end

  assign re         = sync_q[0].win;
  assign pxlAddr    = pxl_addr_q;
  assign vgaR       = vga_r_q;
  assign vgaG       = vga_g_q;
  assign vgaB       = vga_b_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign blank_n    = blank_n_q;
  assign frameStart = frame_start_q;

endmodule

// File: tb/tb_vga_scanner.sv
// Directed bench: three scanners (default window, 256x256 window, enable-abort case)
// run side by side against hand-derived raster positions.
module tb_vga_scanner;

  localparam int FRAME = 800 * 525;

  logic rd_clk = 1'b0;
  always #20 rd_clk = ~rd_clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string who, input logic re, input logic [17:0] pa,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic hs, input logic vs, input logic bl, input logic fs);
    check_eq({who, " re"}, re, 0);
    check_eq({who, " pxlAddr"}, pa, 0);
    check_eq({who, " vgaR"}, r, 0);
    check_eq({who, " vgaG"}, g, 0);
    check_eq({who, " vgaB"}, b, 0);
    check_eq({who, " hsync"}, hs, 1);
    check_eq({who, " vsync"}, vs, 1);
    check_eq({who, " blank_n"}, bl, 0);
    check_eq({who, " frameStart"}, fs, 0);
  endtask

  // DUT 0: default parameters
  logic rst0, en0, re0, hs0, vs0, bl0, fs0;
  logic [7:0] r0, g0, b0, vr0, vg0, vb0;
  logic [17:0] pa0;
  // DUT 1: 256x256 window at column 192
  logic rst1, en1, re1, hs1, vs1, bl1, fs1;
  logic [7:0] r1, g1, b1, vr1, vg1, vb1;
  logic [17:0] pa1;
  // DUT 2: default parameters, used for the enable abort
  logic rst2, en2, re2, hs2, vs2, bl2, fs2;
  logic [7:0] r2, g2, b2, vr2, vg2, vb2;
  logic [17:0] pa2;

  vga_scanner u_dut (
    .rdClk(rd_clk), .reset(rst0), .en(en0), .R(r0), .G(g0), .B(b0),
    .re(re0), .pxlAddr(pa0), .vgaR(vr0), .vgaG(vg0), .vgaB(vb0),
    .hsync(hs0), .vsync(vs0), .blank_n(bl0), .frameStart(fs0)
  );

  vga_scanner #(.IMG_W(256), .IMG_H(256), .X0(192)) u_dut_small (
    .rdClk(rd_clk), .reset(rst1), .en(en1), .R(r1), .G(g1), .B(b1),
    .re(re1), .pxlAddr(pa1), .vgaR(vr1), .vgaG(vg1), .vgaB(vb1),
    .hsync(hs1), .vsync(vs1), .blank_n(bl1), .frameStart(fs1)
  );

  vga_scanner u_dut_en (
    .rdClk(rd_clk), .reset(rst2), .en(en2), .R(r2), .G(g2), .B(b2),
    .re(re2), .pxlAddr(pa2), .vgaR(vr2), .vgaG(vg2), .vgaB(vb2),
    .hsync(hs2), .vsync(vs2), .blank_n(bl2), .frameStart(fs2)
  );

  // Behavioural 1-cycle video memories: colour is a slice of the address.
  always @(posedge rd_clk) begin
    r0 <= pa0[7:0];  g0 <= pa0[15:8];  b0 <= {6'd0, pa0[17:16]};
    r1 <= pa1[7:0];  g1 <= pa1[15:8];  b1 <= {6'd0, pa1[17:16]};
    r2 <= pa2[7:0];  g2 <= pa2[15:8];  b2 <= {6'd0, pa2[17:16]};
  end

  initial begin
    fork
      begin : thr_main
        int n1, n3, h3, v3, ea, fs_cnt, fs_k, hs_fall, hs_fall_n;
        int hs_line0, hs_tot, vs_tot, bl_tot, re_tot;
        logic hs_prev, win3;
        logic [17:0] pa_h1, pa_h2;
        fs_cnt = 0; fs_k = 0; hs_fall = 0; hs_fall_n = 0;
        hs_line0 = 0; hs_tot = 0; vs_tot = 0; bl_tot = 0; re_tot = 0;
        hs_prev = 1'b1; pa_h1 = '0; pa_h2 = '0;
        rst0 = 1'b0; en0 = 1'b0;
        repeat (3) @(negedge rd_clk);
        check_idle("main reset", re0, pa0, vr0, vg0, vb0, hs0, vs0, bl0, fs0);
        rst0 = 1'b1; en0 = 1'b1;
        for (int k = 1; k <= FRAME + 90; k++) begin
          @(negedge rd_clk);
          n1 = k - 1;  // raster index seen by stage 1
          if (n1 < FRAME && re0) re_tot++;
          if (n1 == 79) check_eq("re (79,0)", re0, 0);
          if (n1 == 80) begin
            check_eq("re (80,0)", re0, 1);
            check_eq("addr (80,0)", pa0, 0);
          end
          if (n1 == 559) check_eq("addr (559,0)", pa0, 479);
          if (n1 == 560) begin
            check_eq("re (560,0)", re0, 0);
            check_eq("addr hold (560,0)", pa0, 479);
          end
          if (n1 == 880) check_eq("addr (80,1)", pa0, 480);
          if (n1 == 479 * 800 + 559) check_eq("addr (559,479)", pa0, 230399);
          if (n1 == 480 * 800 + 80) begin
            check_eq("re (80,480)", re0, 0);
            check_eq("addr hold (80,480)", pa0, 230399);
          end
          if (n1 == FRAME + 80) begin
            check_eq("re next frame", re0, 1);
            check_eq("addr next frame", pa0, 0);
          end
          if (k >= 3) begin
            n3 = k - 3;  // raster index seen at the outputs
            if (fs0) begin
              fs_cnt++;
              if (fs_cnt == 1) check_eq("frameStart first cycle", k, 3);
              else if (fs_cnt == 2) check_eq("frame cycles", k - fs_k, FRAME);
              fs_k = k;
            end
            if (n3 < FRAME) begin
              h3 = n3 % 800;
              v3 = n3 / 800;
              if (!hs0) hs_tot++;
              if (!hs0 && n3 < 800) hs_line0++;
              if (!vs0) vs_tot++;
              if (bl0) bl_tot++;
              if (hs_prev && !hs0) begin
                hs_fall++;
                if (hs_fall == 1) check_eq("hsync first fall", n3, 656);
                else if (hs_fall == 2) check_eq("line cycles", n3 - hs_fall_n, 800);
                hs_fall_n = n3;
              end
              hs_prev = hs0;
              if ((v3 inside {0, 1, 479, 480}) &&
                  (h3 inside {0, 79, 80, 81, 300, 559, 560, 639, 640})) begin
                win3 = (h3 >= 80) && (h3 < 560) && (v3 < 480);
                ea = win3 ? ((v3 * 480 + h3 - 80) & 255) : 0;
                check_eq($sformatf("vgaR (%0d,%0d)", h3, v3), vr0, ea);
                check_eq($sformatf("blank_n (%0d,%0d)", h3, v3), bl0,
                         ((h3 < 640) && (v3 < 480)) ? 1 : 0);
              end
              if (n3 == 1100 || n3 == 479 * 800 + 559)
                check_eq($sformatf("vgaR vs pxlAddr-2 n=%0d", n3), vr0, pa_h2[7:0]);
              if (n3 == 479 * 800 + 559) begin
                check_eq("vgaG last pixel", vg0, 131);
                check_eq("vgaB last pixel", vb0, 3);
              end
            end
          end
          pa_h2 = pa_h1;
          pa_h1 = pa0;
        end
        check_eq("hsync low line 0", hs_line0, 96);
        check_eq("hsync low frame", hs_tot, 96 * 525);
        check_eq("vsync low frame", vs_tot, 1600);
        check_eq("blank_n high frame", bl_tot, 640 * 480);
        check_eq("re high frame", re_tot, 230400);
        check_eq("frameStart pulses", fs_cnt, 2);
      end

      begin : thr_small
        int n1, re_cnt;
        re_cnt = 0;
        rst1 = 1'b0; en1 = 1'b0;
        repeat (3) @(negedge rd_clk);
        rst1 = 1'b1; en1 = 1'b1;
        for (int k = 1; k <= 491 * 800 + 700; k++) begin
          @(negedge rd_clk);
          n1 = k - 1;
          if (re1) re_cnt++;
          if (n1 == 191) check_eq("small re (191,0)", re1, 0);
          if (n1 == 192) begin
            check_eq("small re (192,0)", re1, 1);
            check_eq("small addr (192,0)", pa1, 0);
          end
          if (n1 == 447) begin
            check_eq("small re (447,0)", re1, 1);
            check_eq("small addr (447,0)", pa1, 255);
          end
          if (n1 == 448) begin
            check_eq("small re (448,0)", re1, 0);
            check_eq("small addr hold (448,0)", pa1, 255);
          end
          if (n1 == 992) check_eq("small addr (192,1)", pa1, 256);
          if (n1 == 255 * 800 + 447) begin
            check_eq("small re (447,255)", re1, 1);
            check_eq("small addr (447,255)", pa1, 65535);
          end
          if (n1 == 256 * 800 + 192) begin
            check_eq("small re (192,256)", re1, 0);
            check_eq("small addr hold (192,256)", pa1, 65535);
          end
          if (k - 3 == 447) check_eq("small vgaR (447,0)", vr1, 255);
          if (k - 3 == 448) check_eq("small vgaR (448,0)", vr1, 0);
        end
        check_eq("small re count", re_cnt, 65536);
        // Counter now at (700,491): outputs show (697,491), inside both sync pulses.
        check_eq("small hsync before reset", hs1, 0);
        check_eq("small vsync before reset", vs1, 0);
        rst1 = 1'b0;
        @(negedge rd_clk);
        check_idle("small mid-frame reset", re1, pa1, vr1, vg1, vb1, hs1, vs1, bl1, fs1);
        rst1 = 1'b1;
        for (int j = 1; j <= 700; j++) begin
          @(negedge rd_clk);
          if (j == 2) check_eq("small fs j2", fs1, 0);
          if (j == 3) check_eq("small fs j3", fs1, 1);
          if (j == 4) check_eq("small fs j4", fs1, 0);
          if (j == 193) begin
            check_eq("small restart re", re1, 1);
            check_eq("small restart addr", pa1, 0);
          end
          if (j == 658) check_eq("small restart hsync 655", hs1, 1);
          if (j == 659) begin
            check_eq("small restart hsync 656", hs1, 0);
            check_eq("small restart vsync", vs1, 1);
          end
        end
      end

      begin : thr_en
        rst2 = 1'b0; en2 = 1'b0;
        repeat (3) @(negedge rd_clk);
        rst2 = 1'b1; en2 = 1'b1;
        repeat (200 * 800 + 300) @(negedge rd_clk);
        // Counter at (300,200); stage 1 shows (299,200).
        check_eq("en re before abort", re2, 1);
        check_eq("en blank_n before abort", bl2, 1);
        en2 = 1'b0;
        for (int j = 1; j <= 10; j++) begin
          @(negedge rd_clk);
          if (j == 1) check_eq("en abort re", re2, 0);
          if (j == 3) begin
            check_eq("en abort hsync", hs2, 1);
            check_eq("en abort vsync", vs2, 1);
            check_eq("en abort blank_n", bl2, 0);
            check_eq("en abort vgaR", vr2, 0);
          end
          if (j == 10) check_eq("en abort frameStart", fs2, 0);
        end
        en2 = 1'b1;
        for (int m = 1; m <= 81; m++) begin
          @(negedge rd_clk);
          if (m == 2) check_eq("en restart fs m2", fs2, 0);
          if (m == 3) check_eq("en restart fs m3", fs2, 1);
          if (m == 4) check_eq("en restart fs m4", fs2, 0);
          if (m == 80) check_eq("en restart re (79,0)", re2, 0);
          if (m == 81) begin
            check_eq("en restart re (80,0)", re2, 1);
            check_eq("en restart addr (80,0)", pa2, 0);
          end
        end
      end
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
